// File: rtl/pl_instruction_decode_if.sv
// Decode-stage bus: upstream handshake, write-back port, flush and the
// registered ID/EX payload with its downstream handshake.
interface pl_instruction_decode_if;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_pc_next;
   logic [31:0] in_instruction;
   logic        wb_reg_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_pc_next;
   logic [31:0] out_immediate;
   logic [31:0] out_pc_adder_result;
   logic [31:0] out_rs1_data;
   logic [31:0] out_rs2_data;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic [4:0]  out_rd;
   logic [3:0]  out_alu_op;
   logic [2:0]  out_cmp_op;
   logic [1:0]  out_mem_op;
   logic [2:0]  out_mem_sel;
   logic [1:0]  out_wb_sel;
   logic        out_reg_we;
   logic        out_alu_data1_sel;
   logic        out_alu_data2_sel;
   logic        out_branch_jump;
   logic        out_illegal;

   modport slave (
      input  flush, in_valid, in_pc, in_pc_next, in_instruction,
      input  wb_reg_we, wb_rd, wb_data, out_ready,
      output in_ready, out_valid, out_pc, out_pc_next, out_immediate,
      output out_pc_adder_result, out_rs1_data, out_rs2_data,
      output out_rs1, out_rs2, out_rd, out_alu_op, out_cmp_op, out_mem_op,
      output out_mem_sel, out_wb_sel, out_reg_we, out_alu_data1_sel,
      output out_alu_data2_sel, out_branch_jump, out_illegal
   );

   modport master (
      output flush, in_valid, in_pc, in_pc_next, in_instruction,
      output wb_reg_we, wb_rd, wb_data, out_ready,
      input  in_ready, out_valid, out_pc, out_pc_next, out_immediate,
      input  out_pc_adder_result, out_rs1_data, out_rs2_data,
      input  out_rs1, out_rs2, out_rd, out_alu_op, out_cmp_op, out_mem_op,
      input  out_mem_sel, out_wb_sel, out_reg_we, out_alu_data1_sel,
      input  out_alu_data2_sel, out_branch_jump, out_illegal
   );
endinterface

// File: rtl/pl_instruction_decode.sv
// RV32I/RV32E decode stage: field decode, register file with write-back
// bypass, load-use hazard detection and the ID/EX pipeline register.
module pl_instruction_decode #(
   parameter int NUM_REGS  = 32,
   parameter int BYPASS_EN = 1,
   parameter int HAZARD_EN = 1
) (
   input logic clk,
   input logic rst,
   pl_instruction_decode_if.slave bus
);
   localparam int         RW   = $clog2(NUM_REGS);
   localparam logic [5:0] NREG = 6'(NUM_REGS);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   // cmp_op reuses branch funct3; 010/011 are free for "never" and "always"
   localparam logic [3:0] ALU_PASS_B = 4'b1111;
   localparam logic [2:0] CMP_NONE   = 3'b010;
   localparam logic [2:0] CMP_ALWAYS = 3'b011;
   localparam logic [1:0] MEM_LOAD   = 2'b01;
   localparam logic [1:0] MEM_STORE  = 2'b10;
   localparam logic [1:0] WB_MEM     = 2'b01;
   localparam logic [1:0] WB_PC4     = 2'b10;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc_next;
      logic [31:0] imm;
      logic [31:0] pc_sum;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [3:0]  alu_op;
      logic [2:0]  cmp_op;
      logic [1:0]  mem_op;
      logic [2:0]  mem_sel;
      logic [1:0]  wb_sel;
      logic        reg_we;
      logic        alu_d1_sel;
      logic        alu_d2_sel;
      logic        branch_jump;
      logic        illegal;
   } idex_t;

   idex_t              dec_p0;
   idex_t              ex_p1;
   logic               vld_p1;
   logic [31:0]        rf [NUM_REGS];
   logic [31:0]        ins_p0;
   logic [4:0]         rs1_p0, rs2_p0, rd_p0;
   logic [2:0]         f3_p0;
   logic signed [31:0] imm_p0;
   logic [31:0]        stored1_p0, stored2_p0;
   logic               hazard, advance, accept;

   function automatic logic idx_legal(input logic [4:0] idx);
      return {1'b0, idx} < NREG;
   endfunction

   function automatic logic [31:0] read_operand(input logic [4:0] idx, input logic [31:0] stored,
                                                input logic wb_we, input logic [4:0] wb_idx,
                                                input logic [31:0] wb_val);
      if (!idx_legal(idx) || idx == 5'd0) return '0;
      if (BYPASS_EN != 0 && wb_we && wb_idx == idx) return wb_val;
      return stored;
   endfunction

   function automatic logic signed [31:0] imm_decode(input logic [31:0] ins);
      case (ins[6:0])
         OP_LUI, OP_AUIPC: return $signed({ins[31:12], 12'd0});
         OP_JAL:           return $signed({{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0});
         OP_BRANCH:        return $signed({{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0});
         OP_STORE:         return $signed({{21{ins[31]}}, ins[30:25], ins[11:7]});
         OP_JALR, OP_LOAD, OP_IMM: return $signed({{21{ins[31]}}, ins[30:20]});
         default:          return '0;
      endcase
   endfunction

   assign ins_p0     = bus.in_instruction;
   assign rs1_p0     = ins_p0[19:15];
   assign rs2_p0     = ins_p0[24:20];
   assign rd_p0      = ins_p0[11:7];
   assign f3_p0      = ins_p0[14:12];
   assign imm_p0     = imm_decode(ins_p0);
   assign stored1_p0 = rf[rs1_p0[RW-1:0]];
   assign stored2_p0 = rf[rs2_p0[RW-1:0]];

   // Stage p0: combinational decode and operand read
   always_comb begin
      dec_p0          = '0;
      dec_p0.pc       = bus.in_pc;
      dec_p0.pc_next  = bus.in_pc_next;
      dec_p0.imm      = $unsigned(imm_p0);
      dec_p0.pc_sum   = bus.in_pc + $unsigned(imm_p0);
      dec_p0.rs1      = rs1_p0;
      dec_p0.rs2      = rs2_p0;
      dec_p0.rd       = rd_p0;
      dec_p0.rs1_data = read_operand(rs1_p0, stored1_p0, bus.wb_reg_we, bus.wb_rd, bus.wb_data);
      dec_p0.rs2_data = read_operand(rs2_p0, stored2_p0, bus.wb_reg_we, bus.wb_rd, bus.wb_data);
      dec_p0.illegal  = !(idx_legal(rs1_p0) && idx_legal(rs2_p0) && idx_legal(rd_p0));
      dec_p0.cmp_op   = CMP_NONE;
      case (ins_p0[6:0])
         OP_LUI:    begin dec_p0.reg_we = 1'b1; dec_p0.alu_op = ALU_PASS_B; dec_p0.alu_d2_sel = 1'b1; end
         OP_AUIPC:  begin dec_p0.reg_we = 1'b1; dec_p0.alu_d1_sel = 1'b1; dec_p0.alu_d2_sel = 1'b1; end
         OP_JAL: begin
            dec_p0.reg_we      = 1'b1;
            dec_p0.alu_d1_sel  = 1'b1;
            dec_p0.alu_d2_sel  = 1'b1;
            dec_p0.wb_sel      = WB_PC4;
            dec_p0.branch_jump = 1'b1;
            dec_p0.cmp_op      = CMP_ALWAYS;
         end
         OP_JALR: begin
            dec_p0.reg_we      = 1'b1;
            dec_p0.alu_d2_sel  = 1'b1;
            dec_p0.wb_sel      = WB_PC4;
            dec_p0.branch_jump = 1'b1;
            dec_p0.cmp_op      = CMP_ALWAYS;
         end
         OP_BRANCH: begin
            dec_p0.alu_d1_sel  = 1'b1;
            dec_p0.alu_d2_sel  = 1'b1;
            dec_p0.branch_jump = 1'b1;
            dec_p0.cmp_op      = f3_p0;
         end
         OP_LOAD: begin
            dec_p0.reg_we     = 1'b1;
            dec_p0.alu_d2_sel = 1'b1;
            dec_p0.mem_op     = MEM_LOAD;
            dec_p0.mem_sel    = f3_p0;
            dec_p0.wb_sel     = WB_MEM;
         end
         OP_STORE:  begin dec_p0.alu_d2_sel = 1'b1; dec_p0.mem_op = MEM_STORE; dec_p0.mem_sel = f3_p0; end
         OP_IMM: begin
            dec_p0.reg_we     = 1'b1;
            dec_p0.alu_d2_sel = 1'b1;
            dec_p0.alu_op     = {f3_p0 == 3'b101 && ins_p0[30], f3_p0};
         end
         OP_REG:    begin dec_p0.reg_we = 1'b1; dec_p0.alu_op = {ins_p0[30], f3_p0}; end
         default:   ;
      endcase
      if (dec_p0.illegal) dec_p0.reg_we = 1'b0;
   end

   // Hazard is conservative: any rs field match, whether or not the format reads it
   assign hazard  = (HAZARD_EN != 0) && vld_p1 && ex_p1.mem_op == MEM_LOAD && ex_p1.rd != 5'd0 &&
                    (ex_p1.rd == rs1_p0 || ex_p1.rd == rs2_p0);
   assign advance = !vld_p1 || bus.out_ready;
   assign bus.in_ready = !rst && !bus.flush && !hazard && advance;
   assign accept  = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      end else if (bus.wb_reg_we && bus.wb_rd != 5'd0 && idx_legal(bus.wb_rd)) begin
         rf[bus.wb_rd[RW-1:0]] <= bus.wb_data;
      end
   end

   // Stage p1: ID/EX register; a bubble or flush leaves stale payload behind
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1 <= 1'b0;
      end else if (bus.flush) begin
         vld_p1 <= 1'b0;
      end else if (advance) begin
         vld_p1 <= accept;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_p1 <= '0;
      end else if (accept) begin
         ex_p1 <= dec_p0;
      end
   end

   assign bus.out_valid           = vld_p1;
   assign bus.out_pc              = ex_p1.pc;
   assign bus.out_pc_next         = ex_p1.pc_next;
   assign bus.out_immediate       = ex_p1.imm;
   assign bus.out_pc_adder_result = ex_p1.pc_sum;
   assign bus.out_rs1_data        = ex_p1.rs1_data;
   assign bus.out_rs2_data        = ex_p1.rs2_data;
   assign bus.out_rs1             = ex_p1.rs1;
   assign bus.out_rs2             = ex_p1.rs2;
   assign bus.out_rd              = ex_p1.rd;
   assign bus.out_alu_op          = ex_p1.alu_op;
   assign bus.out_cmp_op          = ex_p1.cmp_op;
   assign bus.out_mem_op          = ex_p1.mem_op;
   assign bus.out_mem_sel         = ex_p1.mem_sel;
   assign bus.out_wb_sel          = ex_p1.wb_sel;
   assign bus.out_reg_we          = ex_p1.reg_we;
   assign bus.out_alu_data1_sel   = ex_p1.alu_d1_sel;
   assign bus.out_alu_data2_sel   = ex_p1.alu_d2_sel;
   assign bus.out_branch_jump     = ex_p1.branch_jump;
   assign bus.out_illegal         = ex_p1.illegal;
endmodule

// File: tb/tb_pl_instruction_decode.sv
// Directed bench: a full RV32I instance (bypass + hazard) beside an RV32E
// instance with bypass and hazard disabled, both fed the same stream.
module tb_pl_instruction_decode;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   localparam logic [31:0] I_ADDI_X1   = 32'h0050_0093;
   localparam logic [31:0] I_LW_X5     = 32'h0000_A283;
   localparam logic [31:0] I_ADD_X6_X5 = 32'h0002_8333;
   localparam logic [31:0] I_ADD_X3_X2 = 32'h0021_01B3;
   localparam logic [31:0] I_ADD_X17   = 32'h0020_88B3;
   localparam logic [31:0] I_ADD_X7_X4 = 32'h0002_03B3;
   localparam logic [31:0] I_ADD_X8_20 = 32'h000A_0433;
   localparam logic [31:0] I_BEQ_M8    = 32'hFE20_8CE3;

   pl_instruction_decode_if ia ();
   pl_instruction_decode_if ib ();

   assign ib.flush          = ia.flush;
   assign ib.in_valid       = ia.in_valid;
   assign ib.in_pc          = ia.in_pc;
   assign ib.in_pc_next     = ia.in_pc_next;
   assign ib.in_instruction = ia.in_instruction;
   assign ib.wb_reg_we      = ia.wb_reg_we;
   assign ib.wb_rd          = ia.wb_rd;
   assign ib.wb_data        = ia.wb_data;
   assign ib.out_ready      = ia.out_ready;

   pl_instruction_decode #(.NUM_REGS(32), .BYPASS_EN(1), .HAZARD_EN(1)) dut_a (
      .clk(clk), .rst(rst), .bus(ia.slave));
   pl_instruction_decode #(.NUM_REGS(16), .BYPASS_EN(0), .HAZARD_EN(0)) dut_b (
      .clk(clk), .rst(rst), .bus(ib.slave));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [31:0] ins, input logic [31:0] pc);
      ia.in_valid       = 1'b1;
      ia.in_instruction = ins;
      ia.in_pc          = pc;
      ia.in_pc_next     = pc + 32'd4;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ia.flush = 1'b0; ia.in_valid = 1'b0; ia.in_pc = '0; ia.in_pc_next = '0;
      ia.in_instruction = '0; ia.wb_reg_we = 1'b0; ia.wb_rd = '0; ia.wb_data = '0;
      ia.out_ready = 1'b1;
      repeat (2) tick();
      check("rst_vld_a", 32'(ia.out_valid), 0);
      check("rst_rdy_a", 32'(ia.in_ready), 0);
      check("rst_pc_a", ia.out_pc, 0);
      check("rst_imm_a", ia.out_immediate, 0);
      check("rst_vld_b", 32'(ib.out_valid), 0);
      rst = 1'b0;
      #1;
      check("post_rst_rdy", 32'(ia.in_ready), 1);

      // Load, then asynchronous reset while the dependent add is stalled
      present(I_LW_X5, 32'h200);
      tick();
      check("lw_vld", 32'(ia.out_valid), 1);
      check("lw_memop", 32'(ia.out_mem_op), 1);
      check("lw_rd", 32'(ia.out_rd), 5);
      check("lw_memsel", 32'(ia.out_mem_sel), 2);
      check("lw_wbsel", 32'(ia.out_wb_sel), 1);
      present(I_ADD_X6_X5, 32'h204);
      #1;
      check("stall_rdy_a", 32'(ia.in_ready), 0);
      check("stall_rdy_b", 32'(ib.in_ready), 1);
      rst = 1'b1;
      #1;
      check("midrst_vld", 32'(ia.out_valid), 0);
      check("midrst_rd", 32'(ia.out_rd), 0);
      check("midrst_rdy", 32'(ia.in_ready), 0);
      rst = 1'b0;
      #1;
      check("midrst_nohaz", 32'(ia.in_ready), 1);
      tick();
      check("add6_vld", 32'(ia.out_valid), 1);
      check("add6_rd", 32'(ia.out_rd), 6);
      check("add6_rs1", 32'(ia.out_rs1), 5);

      present(I_ADDI_X1, 32'h100);
      tick();
      check("addi_vld", 32'(ia.out_valid), 1);
      check("addi_rd", 32'(ia.out_rd), 1);
      check("addi_imm", ia.out_immediate, 5);
      check("addi_we", 32'(ia.out_reg_we), 1);
      check("addi_rs1d", ia.out_rs1_data, 0);
      check("addi_pcsum", ia.out_pc_adder_result, 32'h105);
      check("addi_d2sel", 32'(ia.out_alu_data2_sel), 1);
      check("addi_pcnext", ia.out_pc_next, 32'h104);
      ia.in_valid = 1'b0;
      tick();
      check("idle_vld", 32'(ia.out_valid), 0);

      // Write-back of x2 in the same cycle add x3,x2,x2 decodes
      ia.wb_reg_we = 1'b1; ia.wb_rd = 5'd2; ia.wb_data = 32'hDEAD_BEEF;
      present(I_ADD_X3_X2, 32'h110);
      tick();
      check("byp_rs1_a", ia.out_rs1_data, 32'hDEAD_BEEF);
      check("byp_rs2_a", ia.out_rs2_data, 32'hDEAD_BEEF);
      check("nobyp_rs1_b", ib.out_rs1_data, 0);
      ia.wb_reg_we = 1'b0;
      present(I_ADD_X3_X2, 32'h114);
      tick();
      check("rf_rs1_b", ib.out_rs1_data, 32'hDEAD_BEEF);
      check("rf_rs2_a", ia.out_rs2_data, 32'hDEAD_BEEF);

      // x20 write: stored in the RV32 file, dropped (not aliased) in RV32E
      ia.in_valid = 1'b0;
      ia.wb_reg_we = 1'b1; ia.wb_rd = 5'd20; ia.wb_data = 32'h1234_5678;
      tick();
      ia.wb_reg_we = 1'b0;
      present(I_ADD_X17, 32'h120);
      tick();
      check("ill_b", 32'(ib.out_illegal), 1);
      check("ill_we_b", 32'(ib.out_reg_we), 0);
      check("ill_rs2d_b", ib.out_rs2_data, 32'hDEAD_BEEF);
      check("ill_a", 32'(ia.out_illegal), 0);
      check("ill_we_a", 32'(ia.out_reg_we), 1);
      present(I_ADD_X7_X4, 32'h124);
      tick();
      check("x4_alias_b", ib.out_rs1_data, 0);
      present(I_ADD_X8_20, 32'h128);
      tick();
      check("x20_a", ia.out_rs1_data, 32'h1234_5678);
      check("x20_b", ib.out_rs1_data, 0);
      check("x20_ill_b", 32'(ib.out_illegal), 1);

      // Load-use: one bubble in the hazard-enabled instance only
      present(I_LW_X5, 32'h300);
      tick();
      present(I_ADD_X6_X5, 32'h304);
      #1;
      check("lu_rdy_a", 32'(ia.in_ready), 0);
      check("lu_rdy_b", 32'(ib.in_ready), 1);
      tick();
      check("lu_bubble_a", 32'(ia.out_valid), 0);
      check("lu_vld_b", 32'(ib.out_valid), 1);
      check("lu_pc_b", ib.out_pc, 32'h304);
      check("lu_rdy2_a", 32'(ia.in_ready), 1);
      tick();
      check("lu_vld_a", 32'(ia.out_valid), 1);
      check("lu_pc_a", ia.out_pc, 32'h304);
      check("lu_rd_a", 32'(ia.out_rd), 6);
      ia.in_valid = 1'b0;
      tick();
      check("lu_end_a", 32'(ia.out_valid), 0);

      // Backpressure for three cycles
      present(I_ADDI_X1, 32'h400);
      tick();
      ia.out_ready = 1'b0;
      present(I_ADD_X3_X2, 32'h404);
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp_rdy", 32'(ia.in_ready), 0);
         tick();
         check("bp_vld", 32'(ia.out_valid), 1);
         check("bp_pc", ia.out_pc, 32'h400);
         check("bp_rd", 32'(ia.out_rd), 1);
      end
      ia.out_ready = 1'b1;
      #1;
      check("bp_release_rdy", 32'(ia.in_ready), 1);
      tick();
      check("bp_next_pc", ia.out_pc, 32'h404);
      check("bp_next_rd", 32'(ia.out_rd), 3);
      ia.in_valid = 1'b0;
      tick();
      check("bp_nodup", 32'(ia.out_valid), 0);

      // Flush while stalled downstream
      present(I_ADDI_X1, 32'h500);
      tick();
      ia.out_ready = 1'b0; ia.flush = 1'b1;
      present(I_ADD_X3_X2, 32'h504);
      #1;
      check("fl_rdy", 32'(ia.in_ready), 0);
      tick();
      check("fl_vld", 32'(ia.out_valid), 0);
      ia.flush = 1'b0; ia.in_valid = 1'b0; ia.out_ready = 1'b1;
      tick();
      check("fl_noaccept", 32'(ia.out_valid), 0);
      check("fl_stale_pc", ia.out_pc, 32'h500);

      // Flush coinciding with a load-use hazard
      present(I_LW_X5, 32'h600);
      tick();
      ia.flush = 1'b1;
      present(I_ADD_X6_X5, 32'h604);
      tick();
      check("flhz_vld", 32'(ia.out_valid), 0);
      ia.flush = 1'b0;
      tick();
      check("flhz_next_vld", 32'(ia.out_valid), 1);
      check("flhz_next_pc", ia.out_pc, 32'h604);

      // Branch with negative B-immediate
      present(I_BEQ_M8, 32'h700);
      tick();
      check("beq_imm", ia.out_immediate, 32'hFFFF_FFF8);
      check("beq_pcsum", ia.out_pc_adder_result, 32'h6F8);
      check("beq_bj", 32'(ia.out_branch_jump), 1);
      check("beq_we", 32'(ia.out_reg_we), 0);
      check("beq_cmp", 32'(ia.out_cmp_op), 0);
      check("beq_d1sel", 32'(ia.out_alu_data1_sel), 1);
      ia.in_valid = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
